// File: rtl/sloth_eval_driver.sv
// Fitness-evaluation driver: streams LFSR operand vectors to a candidate and a golden model,
// scoring the Hamming distance between their outputs into a saturating accumulator.
module sloth_eval_driver #(
    parameter int unsigned  NUM_VECTORS  = 256,
    parameter int unsigned  SCORE_W      = 24,
    parameter logic [15:0]  DEFAULT_SEED = 16'hACE1
) (
    input  logic               clk,
    input  logic               rst_n,
    input  logic               start,
    input  logic [15:0]        seed_in,
    output logic [15:0]        a1,
    output logic [15:0]        a0,
    output logic [15:0]        b1,
    output logic [15:0]        b0,
    input  logic [15:0]        y3,
    input  logic [15:0]        y2,
    input  logic [15:0]        y1,
    input  logic [15:0]        y0,
    input  logic [15:0]        g3,
    input  logic [15:0]        g2,
    input  logic [15:0]        g1,
    input  logic [15:0]        g0,
    output logic               busy,
    output logic               done,
    output logic [SCORE_W-1:0] score,
    output logic               perfect,
    output logic [15:0]        vec_count
);

    typedef enum logic [2:0] {S_IDLE, S_LOAD, S_DRIVE, S_SAMPLE, S_DONE} state_t;

    state_t               r_state, w_next;
    logic [15:0]          r_lfsr, r_a1, r_a0, r_b1, r_b0, r_vec_count;
    logic                 r_busy, r_done, r_perfect;
    logic [SCORE_W-1:0]   r_score, w_score_next;
    logic [15:0]          w_s1, w_s2, w_s3, w_s4, w_seed, w_vec_inc;
    logic [63:0]          w_diff;
    logic [6:0]           w_dist;
    logic [SCORE_W:0]     w_sum;
    logic                 w_last;

    function automatic logic [15:0] lfsr_step(input logic [15:0] l);
        return {1'b0, l[15:1]} ^ (l[0] ? 16'hB400 : 16'h0000);
    endfunction

    assign w_s1      = lfsr_step(r_lfsr);
    assign w_s2      = lfsr_step(w_s1);
    assign w_s3      = lfsr_step(w_s2);
    assign w_s4      = lfsr_step(w_s3);
    assign w_seed    = (seed_in == 16'h0000) ? DEFAULT_SEED : seed_in;
    assign w_vec_inc = r_vec_count + 16'd1;
    assign w_last    = (w_vec_inc == NUM_VECTORS[15:0]);
    assign w_diff    = {y3 ^ g3, y2 ^ g2, y1 ^ g1, y0 ^ g0};

    always_comb begin
        w_dist = '0;
        for (int unsigned i = 0; i < 64; i++)
            w_dist = w_dist + {6'd0, w_diff[i]};
    end

    // One extra accumulator bit catches the carry so the score clamps instead of wrapping.
    assign w_sum        = {1'b0, r_score} + {{(SCORE_W-6){1'b0}}, w_dist};
    assign w_score_next = w_sum[SCORE_W] ? '1 : w_sum[SCORE_W-1:0];

    always_comb begin
        w_next = r_state;
        case (r_state)
            S_IDLE, S_DONE: if (start) w_next = S_LOAD;
            S_LOAD:         w_next = S_DRIVE;
            S_DRIVE:        w_next = S_SAMPLE;
            S_SAMPLE:       w_next = w_last ? S_DONE : S_DRIVE;
            default:        w_next = S_IDLE;
        endcase
    end

    // Status outputs are registered from the current state, so they lag the state by one edge.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state     <= S_IDLE;
            r_lfsr      <= DEFAULT_SEED;
            r_a1        <= '0;
            r_a0        <= '0;
            r_b1        <= '0;
            r_b0        <= '0;
            r_busy      <= 1'b0;
            r_done      <= 1'b0;
            r_perfect   <= 1'b0;
            r_score     <= '0;
            r_vec_count <= '0;
        end else begin
            r_state <= w_next;
            case (r_state)
                S_IDLE, S_DONE: begin
                    if (start) begin
                        r_score     <= '0;
                        r_vec_count <= '0;
                        r_done      <= 1'b0;
                        r_perfect   <= 1'b0;
                        r_lfsr      <= w_seed;
                    end else if (r_state == S_DONE) begin
                        r_busy    <= 1'b0;
                        r_done    <= 1'b1;
                        r_perfect <= (r_score == '0);
                    end
                end
                S_LOAD: r_busy <= 1'b1;
                S_DRIVE: begin
                    r_a0   <= w_s1;
                    r_a1   <= w_s2;
                    r_b0   <= w_s3;
                    r_b1   <= w_s4;
                    r_lfsr <= w_s4;
                end
                S_SAMPLE: begin
                    r_score     <= w_score_next;
                    r_vec_count <= w_vec_inc;
                end
                default: ;
            endcase
        end
    end

    assign a1        = r_a1;
    assign a0        = r_a0;
    assign b1        = r_b1;
    assign b0        = r_b0;
    assign busy      = r_busy;
    assign done      = r_done;
    assign perfect   = r_perfect;
    assign score     = r_score;
    assign vec_count = r_vec_count;

endmodule

// File: tb/tb_sloth_eval_driver.sv
// Randomized bench for sloth_eval_driver: two instances (N=4/W=24 and N=8/W=8) checked
// edge by edge against a reference built from the LFSR and scoring rules.
module tb_sloth_eval_driver;

    logic        clk, rst_n;
    logic        start_a, start_b;
    logic [15:0] seed_a, seed_b;
    logic [15:0] m3, m2, m1, m0;
    logic        uv;
    logic        sel;

    logic [15:0] aa1, aa0, ab1, ab0, ya3, ya2, ya1, ya0, ga3, ga2, ga1, ga0, vc_a;
    logic [15:0] ba1, ba0, bb1, bb0, yb3, yb2, yb1, yb0, gb3, gb2, gb1, gb0, vc_b;
    logic        busy_a, done_a, perfect_a, busy_b, done_b, perfect_b;
    logic [23:0] score_a;
    logic [7:0]  score_b;

    logic [15:0] o_a1, o_a0, o_b1, o_b0, o_vc;
    logic        o_busy, o_done, o_perfect;
    logic [31:0] o_score;

    int n_checks = 0;
    int n_fail   = 0;

    logic [15:0] ea1 [1:8], ea0 [1:8], eb1 [1:8], eb0 [1:8];
    logic [31:0] epart [0:8];
    logic [15:0] cap_a1, cap_a0, cap_b1, cap_b0;

    // Candidate is an arbitrary combinational function; golden flips masked bits of it.
    assign ya3 = aa1 + ab1;
    assign ya2 = aa0 ^ ab0;
    assign ya1 = {aa1[7:0], ab0[15:8]};
    assign ya0 = aa0 - ab1;
    assign ga3 = ya3 ^ (m3 & (uv ? aa0 : 16'hFFFF));
    assign ga2 = ya2 ^ (m2 & (uv ? aa1 : 16'hFFFF));
    assign ga1 = ya1 ^ (m1 & (uv ? ab0 : 16'hFFFF));
    assign ga0 = ya0 ^ (m0 & (uv ? ab1 : 16'hFFFF));

    assign yb3 = ba1 + bb1;
    assign yb2 = ba0 ^ bb0;
    assign yb1 = {ba1[7:0], bb0[15:8]};
    assign yb0 = ba0 - bb1;
    assign gb3 = yb3 ^ (m3 & (uv ? ba0 : 16'hFFFF));
    assign gb2 = yb2 ^ (m2 & (uv ? ba1 : 16'hFFFF));
    assign gb1 = yb1 ^ (m1 & (uv ? bb0 : 16'hFFFF));
    assign gb0 = yb0 ^ (m0 & (uv ? bb1 : 16'hFFFF));

    sloth_eval_driver #(.NUM_VECTORS(4), .SCORE_W(24), .DEFAULT_SEED(16'hACE1)) u_dut_a (
        .clk(clk), .rst_n(rst_n), .start(start_a), .seed_in(seed_a),
        .a1(aa1), .a0(aa0), .b1(ab1), .b0(ab0),
        .y3(ya3), .y2(ya2), .y1(ya1), .y0(ya0),
        .g3(ga3), .g2(ga2), .g1(ga1), .g0(ga0),
        .busy(busy_a), .done(done_a), .score(score_a), .perfect(perfect_a), .vec_count(vc_a)
    );

    sloth_eval_driver #(.NUM_VECTORS(8), .SCORE_W(8), .DEFAULT_SEED(16'hACE1)) u_dut_b (
        .clk(clk), .rst_n(rst_n), .start(start_b), .seed_in(seed_b),
        .a1(ba1), .a0(ba0), .b1(bb1), .b0(bb0),
        .y3(yb3), .y2(yb2), .y1(yb1), .y0(yb0),
        .g3(gb3), .g2(gb2), .g1(gb1), .g0(gb0),
        .busy(busy_b), .done(done_b), .score(score_b), .perfect(perfect_b), .vec_count(vc_b)
    );

    always_comb begin
        o_a1      = sel ? ba1 : aa1;
        o_a0      = sel ? ba0 : aa0;
        o_b1      = sel ? bb1 : ab1;
        o_b0      = sel ? bb0 : ab0;
        o_vc      = sel ? vc_b : vc_a;
        o_busy    = sel ? busy_b : busy_a;
        o_done    = sel ? done_b : done_a;
        o_perfect = sel ? perfect_b : perfect_a;
        o_score   = sel ? {24'd0, score_b} : {8'd0, score_a};
    end

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: observed %0h expected %0h", tag, got, exp);
        end
    endtask

    function automatic logic [15:0] step(input logic [15:0] l);
        logic [15:0] r;
        r = l >> 1;
        if (l[0]) r = r ^ 16'hB400;
        return r;
    endfunction

    function automatic int pop(input logic [15:0] v);
        return $countones(v);
    endfunction

    task automatic check_reset(input string tag);
        check_eq({tag, " a1"}, {16'd0, o_a1}, 32'd0);
        check_eq({tag, " a0"}, {16'd0, o_a0}, 32'd0);
        check_eq({tag, " b1"}, {16'd0, o_b1}, 32'd0);
        check_eq({tag, " b0"}, {16'd0, o_b0}, 32'd0);
        check_eq({tag, " busy"}, {31'd0, o_busy}, 32'd0);
        check_eq({tag, " done"}, {31'd0, o_done}, 32'd0);
        check_eq({tag, " perfect"}, {31'd0, o_perfect}, 32'd0);
        check_eq({tag, " score"}, o_score, 32'd0);
        check_eq({tag, " vec_count"}, {16'd0, o_vc}, 32'd0);
    endtask

    task automatic set_start(input logic v, input logic [15:0] s);
        if (sel) begin start_b = v; seed_b = s; end
        else     begin start_a = v; seed_a = s; end
    endtask

    // inj_edge: edge (counted from acceptance) over which a stray start is held;
    // rst_edge: edge after which rst_n is pulsed and the run abandoned.
    task automatic run(input logic s, input logic [15:0] seed, input int n, input int w,
                       input int inj_edge, input int rst_edge);
        logic [15:0] l;
        logic [31:0] maxv, sum;
        int d;
        maxv = (32'd1 << w) - 32'd1;
        l = (seed == 16'h0000) ? 16'hACE1 : seed;
        epart[0] = 32'd0;
        for (int k = 1; k <= n; k++) begin
            l = step(l); ea0[k] = l;
            l = step(l); ea1[k] = l;
            l = step(l); eb0[k] = l;
            l = step(l); eb1[k] = l;
            d = pop(m3 & (uv ? ea0[k] : 16'hFFFF)) + pop(m2 & (uv ? ea1[k] : 16'hFFFF))
              + pop(m1 & (uv ? eb0[k] : 16'hFFFF)) + pop(m0 & (uv ? eb1[k] : 16'hFFFF));
            sum = epart[k-1] + 32'(d);
            epart[k] = (sum > maxv) ? maxv : sum;
        end

        @(negedge clk);
        sel = s;
        set_start(1'b1, seed);
        @(posedge clk);
        #1;
        set_start(1'b0, 16'h0000);
        check_eq("accept busy", {31'd0, o_busy}, 32'd0);
        check_eq("accept done", {31'd0, o_done}, 32'd0);
        check_eq("accept score", o_score, 32'd0);
        check_eq("accept vec_count", {16'd0, o_vc}, 32'd0);

        for (int e = 1; e <= 2*n + 2; e++) begin
            if (e == inj_edge) set_start(1'b1, 16'(($urandom % 16'hFFFF) + 1));
            @(posedge clk);
            #1;
            set_start(1'b0, 16'h0000);
            if (e == rst_edge) begin
                #2 rst_n = 1'b0;
                #1 check_reset($sformatf("midrun reset e%0d", e));
                #2 rst_n = 1'b1;
                return;
            end
            if (e == 2) begin
                cap_a0 = o_a0; cap_a1 = o_a1; cap_b0 = o_b0; cap_b1 = o_b1;
            end
            if (e % 2 == 0 && e <= 2*n) begin
                check_eq($sformatf("a0 v%0d", e/2), {16'd0, o_a0}, {16'd0, ea0[e/2]});
                check_eq($sformatf("a1 v%0d", e/2), {16'd0, o_a1}, {16'd0, ea1[e/2]});
                check_eq($sformatf("b0 v%0d", e/2), {16'd0, o_b0}, {16'd0, eb0[e/2]});
                check_eq($sformatf("b1 v%0d", e/2), {16'd0, o_b1}, {16'd0, eb1[e/2]});
            end
            if (e % 2 == 1 && e >= 3) begin
                check_eq($sformatf("score v%0d", (e-1)/2), o_score, epart[(e-1)/2]);
                check_eq($sformatf("vec_count v%0d", (e-1)/2), {16'd0, o_vc}, 32'((e-1)/2));
            end
            if (e <= 2*n + 1) begin
                check_eq($sformatf("busy e%0d", e), {31'd0, o_busy}, 32'd1);
                check_eq($sformatf("done e%0d", e), {31'd0, o_done}, 32'd0);
            end
        end
        for (int t = 0; t < 3; t++) begin
            check_eq("final busy", {31'd0, o_busy}, 32'd0);
            check_eq("final done", {31'd0, o_done}, 32'd1);
            check_eq("final score", o_score, epart[n]);
            check_eq("final perfect", {31'd0, o_perfect}, {31'd0, epart[n] == 32'd0});
            check_eq("final vec_count", {16'd0, o_vc}, 32'(n));
            check_eq("operand hold a0", {16'd0, o_a0}, {16'd0, ea0[n]});
            @(posedge clk);
            #1;
        end
    endtask

    task automatic rand_masks();
        m3 = 16'($urandom); m2 = 16'($urandom); m1 = 16'($urandom); m0 = 16'($urandom);
        uv = 1'($urandom);
    endtask

    initial begin
        rst_n = 1'b1; start_a = 1'b0; start_b = 1'b0; seed_a = '0; seed_b = '0;
        m3 = '0; m2 = '0; m1 = '0; m0 = '0; uv = 1'b0; sel = 1'b0;
        #1 rst_n = 1'b0;
        #2 check_reset("reset A");
        sel = 1'b1;
        #1 check_reset("reset B");
        #18 rst_n = 1'b1;

        // loopback: golden equals candidate
        run(1'b0, 16'h0001, 4, 24, -1, -1);
        check_eq("loopback first a0", {16'd0, cap_a0}, 32'h0000B400);
        check_eq("loopback first a1", {16'd0, cap_a1}, 32'h00005A00);
        check_eq("loopback first b0", {16'd0, cap_b0}, 32'h00002D00);
        check_eq("loopback first b1", {16'd0, cap_b1}, 32'h00001680);
        check_eq("loopback perfect", {31'd0, o_perfect}, 32'd1);

        // golden g0 inverted
        m0 = 16'hFFFF;
        run(1'b0, 16'h1234, 4, 24, -1, -1);
        check_eq("g0 inverted score", o_score, 32'd64);
        check_eq("g0 inverted perfect", {31'd0, o_perfect}, 32'd0);

        // zero seed substitution
        m0 = 16'h0000;
        run(1'b0, 16'h0000, 4, 24, -1, -1);
        check_eq("default seed a0", {16'd0, cap_a0}, 32'h0000E270);

        // saturation on the 8-bit accumulator
        m3 = 16'hFFFF; m2 = 16'hFFFF; m1 = 16'hFFFF; m0 = 16'hFFFF; uv = 1'b0;
        run(1'b1, 16'(($urandom % 16'hFFFF) + 1), 8, 8, -1, -1);
        check_eq("saturated score", o_score, 32'd255);

        // start during SAMPLE of vector 2 is ignored
        rand_masks();
        run(1'b0, 16'(($urandom % 16'hFFFF) + 1), 4, 24, 5, -1);

        // reset during vector 3, then a fresh full run
        rand_masks();
        run(1'b1, 16'(($urandom % 16'hFFFF) + 1), 8, 8, -1, 6);
        rand_masks();
        run(1'b1, 16'(($urandom % 16'hFFFF) + 1), 8, 8, -1, -1);

        for (int r = 0; r < 6; r++) begin
            rand_masks();
            if ($urandom_range(0, 3) == 0) begin
                m3 = '0; m2 = '0; m1 = '0; m0 = 16'(1 << $urandom_range(0, 15)); uv = 1'b0;
            end
            run(1'(r), 16'($urandom), (r % 2 == 1) ? 8 : 4, (r % 2 == 1) ? 8 : 24, -1, -1);
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
